// File: rtl/btn_pkg.sv
// Shared definitions for the button debouncer: per-channel FSM state encoding
// and the default timing constants (100 MHz clock).
// Latency: n/a. Backpressure: n/a.
package btn_pkg;

    typedef enum logic [1:0] {
        REL    = 2'd0,
        WAIT_P = 2'd1,
        HELD   = 2'd2,
        WAIT_R = 2'd3
    } btn_state_t;

    // 10 ms stability window
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    // 500 ms before the first auto-repeat pulse
    localparam int DEF_REPEAT_DELAY    = 50_000_000;
    // 100 ms between subsequent auto-repeat pulses
    localparam int DEF_REPEAT_PERIOD   = 10_000_000;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM with stability counter,
// optional auto-repeat timer (macro BTN_DEBOUNCE_REPEAT_EN).
// Latency: raw edge to level change DEBOUNCE_CYCLES+2 cycles. Backpressure: none.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic rpt
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // The cycle that enters WAIT_P/WAIT_R already counts as the first
    // differing cycle, so the counter only has to reach DEBOUNCE_CYCLES-2.
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES - 2);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 24)) begin : g_bad_debounce
        $error("btn_debounce_ch: DEBOUNCE_CYCLES out of range 2..2^24");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("btn_debounce_ch: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic          sync_meta;
    logic          btn_sync;
    btn_state_t    state;
    logic [CW-1:0] cnt;
    logic          press_now;
    logic          release_now;

    assign press_now   = (state == WAIT_P) && btn_sync  && (cnt == CNT_DONE);
    assign release_now = (state == WAIT_R) && !btn_sync && (cnt == CNT_DONE);

    // Bring the asynchronous pin into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b0;
            btn_sync  <= 1'b0;
        end else begin
            sync_meta <= raw;
            btn_sync  <= sync_meta;
        end
    end

    // Debounce FSM: any bounce back to the current level restarts the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= REL;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            press <= 1'b0;
            rel   <= 1'b0;
            case (state)
                REL: begin
                    if (btn_sync) begin
                        state <= WAIT_P;
                        cnt   <= '0;
                    end
                end
                WAIT_P: begin
                    if (!btn_sync) begin
                        state <= REL;
                        cnt   <= '0;
                    end else if (press_now) begin
                        state <= HELD;
                        cnt   <= '0;
                        level <= 1'b1;
                        press <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!btn_sync) begin
                        state <= WAIT_R;
                        cnt   <= '0;
                    end
                end
                WAIT_R: begin
                    if (btn_sync) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (release_now) begin
                        state <= REL;
                        cnt   <= '0;
                        level <= 1'b0;
                        rel   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= REL;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef BTN_DEBOUNCE_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rcnt;
    logic          held_on;

    // A bounce in WAIT_R keeps the button held, so the timer keeps running;
    // the release cycle itself never repeats.
    assign held_on = ((state == HELD) || (state == WAIT_R)) && !release_now;

    // Down-counter: loaded on press, fires at zero, then reloads with the period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt <= '0;
            rpt  <= 1'b0;
        end else begin
            rpt <= 1'b0;
            if (press_now) begin
                rcnt <= RW'(REPEAT_DELAY - 1);
            end else if (held_on) begin
                if (rcnt == '0) begin
                    rpt  <= 1'b1;
                    rcnt <= RW'(REPEAT_PERIOD - 1);
                end else begin
                    rcnt <= rcnt - 1'b1;
                end
            end else begin
                rcnt <= '0;
            end
        end
    end
`else
    assign rpt = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce.sv
// N_BTN independent debounced buttons with press/release/auto-repeat pulses.
// Latency: DEBOUNCE_CYCLES+2 cycles raw edge to output. Backpressure: none.
// Auto-repeat is built only when BTN_DEBOUNCE_REPEAT_EN is defined.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_rpt
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .raw   (btn_raw[i]),
            .level (btn_level[i]),
            .press (btn_press[i]),
            .rel   (btn_release[i]),
            .rpt   (btn_rpt[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed scenarios plus random bouncing, all
// checked every cycle against a sliding-window reference model.
module tb_btn_debounce;

    localparam int N  = 4;
    localparam int D  = 8;
    localparam int RD = 40;
    localparam int RP = 10;
`ifdef BTN_DEBOUNCE_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_rpt;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    btn_debounce #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_rpt     (btn_rpt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the level flips once the synchronized input has
    // disagreed with it for the last D cycles. The synchronized value seen in
    // a cycle is the raw sample taken two edges earlier, so the window is
    // raw samples t-D-1 .. t-2. Repeats fire RD cycles after press and every
    // RP thereafter, while the level stays high.
    bit [D:0]     hist [N];   // bit k = raw sampled k+1 edges ago
    logic [N-1:0] m_level, m_press, m_release, m_rpt;
    int           m_since [N];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < N; c++) begin
                hist[c]    = '0;
                m_since[c] = 0;
            end
            m_level   = '0;
            m_press   = '0;
            m_release = '0;
            m_rpt     = '0;
        end else begin
            for (int c = 0; c < N; c++) begin
                m_press[c]   = 1'b0;
                m_release[c] = 1'b0;
                m_rpt[c]     = 1'b0;
                if (!m_level[c] && (&hist[c][D:1])) begin
                    m_level[c] = 1'b1;
                    m_press[c] = 1'b1;
                    m_since[c] = 0;
                end else if (m_level[c] && !(|hist[c][D:1])) begin
                    m_level[c]   = 1'b0;
                    m_release[c] = 1'b1;
                end else if (m_level[c]) begin
                    m_since[c]++;
                    if (REP_EN && m_since[c] >= RD && ((m_since[c] - RD) % RP) == 0)
                        m_rpt[c] = 1'b1;
                end
                hist[c] = {hist[c][D-1:0], btn_raw[c]};
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("mon_level",   32'(btn_level),   32'(m_level));
            check("mon_press",   32'(btn_press),   32'(m_press));
            check("mon_release", 32'(btn_release), 32'(m_release));
            check("mon_rpt",     32'(btn_rpt),     32'(m_rpt));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Cycles until the chosen pulse on channel ch appears; -1 if it never does.
    task automatic wait_pulse(input int ch, input bit want_press, input int max_cyc,
                              output int lat);
        lat = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            tick(1);
            if (want_press ? btn_press[ch] : btn_release[ch]) begin
                lat = i;
                return;
            end
        end
    endtask

    initial begin
        int  lat;
        bit  seen;
        bit  exp_rpt;
        int  run [N];

        rst     = 1'b1;
        btn_raw = '0;
        tick(2);
        mon_en = 1'b1;
        check("reset_level", 32'(btn_level), 32'h0);
        check("reset_press", 32'(btn_press | btn_release | btn_rpt), 32'h0);
        rst = 1'b0;
        tick(5);

        // Clean press on channel 0
        btn_raw[0] = 1'b1;
        wait_pulse(0, 1'b1, 30, lat);
        check("clean_press_lat", lat, D + 2);
        check("clean_level_with_press", 32'(btn_level[0]), 32'h1);
        tick(1);
        check("clean_press_single", 32'(btn_press[0]), 32'h0);
        tick(40);
        btn_raw[0] = 1'b0;
        wait_pulse(0, 1'b0, 30, lat);
        check("clean_release_lat", lat, D + 2);

        // Bouncing on channel 2: toggles every 3 cycles must never qualify
        btn_raw[2] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < 3; j++) begin
                tick(1);
                seen |= btn_press[2];
            end
            btn_raw[2] = ~btn_raw[2];
        end
        check("bounce_no_press", 32'(seen), 32'h0);
        wait_pulse(2, 1'b1, 30, lat);
        check("bounce_final_lat", lat, D + 2);

        // Simultaneous press on channels 1 and 3
        btn_raw[2] = 1'b0;
        tick(20);
        btn_raw[1] = 1'b1;
        btn_raw[3] = 1'b1;
        wait_pulse(1, 1'b1, 30, lat);
        check("simul_lat", lat, D + 2);
        check("simul_press_vec", 32'(btn_press), 32'hA);
        btn_raw = '0;
        tick(20);

        // Reset five cycles into WAIT_P, raw stays high
        btn_raw[0] = 1'b1;
        tick(7);
        rst = 1'b1;
        #1;
        check("rst_mid_level", 32'(btn_level), 32'h0);
        check("rst_mid_pulses", 32'(btn_press | btn_release | btn_rpt), 32'h0);
        tick(3);
        rst = 1'b0;
        wait_pulse(0, 1'b1, 30, lat);
        check("rst_repress_lat", lat, D + 2);
        btn_raw[0] = 1'b0;
        tick(20);

        // Hold 100 cycles after press, then release
        btn_raw[0] = 1'b1;
        wait_pulse(0, 1'b1, 30, lat);
        check("hold_press_lat", lat, D + 2);
        for (int k = 1; k <= 100; k++) begin
            tick(1);
            exp_rpt = REP_EN && k >= RD && ((k - RD) % RP) == 0;
            check("hold_rpt", 32'(btn_rpt[0]), 32'(exp_rpt));
        end
        btn_raw[0] = 1'b0;
        seen = 1'b0;
        lat  = -1;
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            seen |= btn_rpt[0];
            if (btn_release[0]) begin
                lat = i;
                break;
            end
        end
        check("hold_release_lat", lat, D + 2);
        check("hold_release_no_rpt", 32'(seen), 32'h0);
        tick(5);

        // Random bouncing with occasional resets
        for (int c = 0; c < N; c++) run[c] = $urandom_range(1, 10);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < N; c++) begin
                run[c]--;
                if (run[c] <= 0) begin
                    btn_raw[c] = ~btn_raw[c];
                    run[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 90)
                                                         : $urandom_range(1, 10);
                end
            end
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                tick($urandom_range(1, 3));
                rst = 1'b0;
            end
            tick(1);
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter N_BTN, default 4: number of independent button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000: stability window in clk cycles (10 ms at 100 MHz), legal range 2..2^24.
REQ-003 SHALL have parameter REPEAT_DELAY, default 50_000_000: hold time in cycles before the first auto-repeat pulse.
REQ-004 SHALL have parameter REPEAT_PERIOD, default 10_000_000: cycles between subsequent auto-repeat pulses.
REQ-005 SHALL have port clk, input, 1: system clock, 100 MHz.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port btn_raw, input, N_BTN: asynchronous button pins, pushed = 1.
REQ-008 SHALL have port btn_level, output, N_BTN: debounced, registered button state.
REQ-009 SHALL have port btn_press, output, N_BTN: one-cycle pulse on each debounced 0->1 transition.
REQ-010 SHALL have port btn_release, output, N_BTN: one-cycle pulse on each debounced 1->0 transition.
REQ-011 SHALL have port btn_rpt, output, N_BTN: one-cycle auto-repeat pulse while a button is held.

Function
REQ-012 SHALL pass each btn_raw bit through a 2-flop synchronizer; the second flop's output is btn_sync.
REQ-013 SHALL run a per-channel FSM with states REL, WAIT_P, HELD and WAIT_R.
REQ-014 SHALL move REL->WAIT_P when btn_sync=1, and HELD->WAIT_R when btn_sync=0, clearing the stability counter on entry.
REQ-015 SHALL, in WAIT_P or WAIT_R, increment the counter each cycle btn_sync differs from btn_level, and return to REL or HELD with the counter cleared on any cycle it matches (bounce).
REQ-016 SHALL, when btn_sync has differed for DEBOUNCE_CYCLES consecutive cycles, toggle btn_level on the next edge, enter HELD or REL, and assert btn_press or btn_release for exactly that one cycle, aligned with the btn_level change.
REQ-017 SHALL have a latency from a clean raw edge to the btn_level change of exactly DEBOUNCE_CYCLES+2 cycles.
REQ-018 SHALL size the counter as $clog2(DEBOUNCE_CYCLES+1) bits and SHALL never let it wrap.
REQ-019 SHALL make btn_press and btn_release mutually exclusive per channel, with at least DEBOUNCE_CYCLES+1 cycles between opposite pulses.
REQ-020 SHALL keep channels fully independent, so simultaneous events on several channels each produce their own pulse in the same cycle.

Reset
REQ-021 SHALL, while rst=1, asynchronously clear synchronizer flops, counters, btn_level, btn_press, btn_release and btn_rpt to 0 and force every FSM to REL.
REQ-022 SHALL, on an assertion of rst mid-debounce, abort the debounce with no pulse emitted.
REQ-023 SHALL treat a button held across reset release as a new press, reported DEBOUNCE_CYCLES+2 cycles after release.

Configuration
REQ-024 SHALL, when macro BTN_DEBOUNCE_REPEAT_EN is defined, pulse btn_rpt once REPEAT_DELAY cycles after btn_press while the channel stays in HELD or WAIT_R, then every REPEAT_PERIOD cycles.
REQ-025 SHALL, with BTN_DEBOUNCE_REPEAT_EN defined, clear the repeat timer on leaving HELD/WAIT_R to REL and never assert btn_rpt in the btn_press cycle.
REQ-026 SHALL, when BTN_DEBOUNCE_REPEAT_EN is undefined, tie btn_rpt to 0 with no repeat timer logic, the port remaining present.

Structure
REQ-027 SHALL place the FSM state encoding (REL, WAIT_P, HELD, WAIT_R) and the default timing constants in shared package btn_pkg.
REQ-028 SHALL implement one channel (synchronizer, FSM, counter, optional repeat timer) in sub-module btn_debounce_ch, instantiated N_BTN times by a generate loop.

Verification (DEBOUNCE_CYCLES=8, REPEAT_DELAY=40, REPEAT_PERIOD=10)
REQ-029 SHALL cover: clean 0->1 on btn_raw[0] held 50 cycles -> btn_level[0] rises exactly 10 cycles after the raw edge, with a single-cycle btn_press[0] in that same cycle.
REQ-030 SHALL cover: raw toggling every 3 cycles for 30 cycles, then high -> no pulse during bouncing, then btn_press 10 cycles after the final edge.
REQ-031 SHALL cover: btn_raw[1] and btn_raw[3] rising in the same cycle -> btn_press=4'b1010 in a single cycle.
REQ-032 SHALL cover: rst asserted 5 cycles into WAIT_P -> all outputs 0 immediately, no pulse, and, raw still high, btn_press 10 cycles after rst falls.
REQ-033 SHALL cover, with REPEAT_EN: hold 100 cycles after btn_press -> btn_rpt at +40, +50, +60, ... +100, then release -> btn_release 10 cycles later and btn_rpt stays 0.
REQ-034 SHALL cover, without REPEAT_EN: the same stimulus as REQ-033 -> btn_rpt constantly 0.
